// File: rtl/basket_controller.sv
//==============================================================================
// Module      : basket_controller
// Description : Customer basket for the sale terminal. Holds up to DEPTH line
//               items (product ID, quantity) and a running total price.
//               Add, remove and clear commands arrive as one-cycle strobes.
//               A slot-scan FSM finds an existing line for the same product,
//               so repeated adds merge into it.
// Ports       : CLOCK_50, RESET         - clock, synchronous active-high reset
//               Enable_Pulse, Op,
//               ProductID,
//               ProductQuantity         - command strobe and operands
//               Busy, Done_Pulse, Error - command status
//               TotalPrice, ItemCount   - basket totals
//               Rd_Index, Rd_Valid,
//               Rd_ProductID,
//               Rd_Quantity             - combinational slot read port
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module basket_controller #(
    parameter  int DEPTH        = 8,
    parameter  int NUM_PRODUCTS = 12,
    parameter  int MAX_QTY      = 99,
    localparam int c_IDX_W      = $clog2(DEPTH)
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               Enable_Pulse,
    input  logic [1:0]         Op,
    input  logic [3:0]         ProductID,
    input  logic [3:0]         ProductQuantity,
    output logic               Busy,
    output logic               Done_Pulse,
    output logic [2:0]         Error,
    output logic [15:0]        TotalPrice,
    output logic [c_IDX_W:0]   ItemCount,
    input  logic [c_IDX_W-1:0] Rd_Index,
    output logic               Rd_Valid,
    output logic [3:0]         Rd_ProductID,
    output logic [6:0]         Rd_Quantity
);

    localparam logic [1:0] c_OP_ADD    = 2'b00;
    localparam logic [1:0] c_OP_REMOVE = 2'b01;
    localparam logic [1:0] c_OP_CLEAR  = 2'b10;
    localparam logic [1:0] c_OP_RSVD   = 2'b11;

    localparam logic [2:0] c_ERR_OK       = 3'd0;
    localparam logic [2:0] c_ERR_BAD_ID   = 3'd1;
    localparam logic [2:0] c_ERR_ZERO_QTY = 3'd2;
    localparam logic [2:0] c_ERR_FULL     = 3'd3;
    localparam logic [2:0] c_ERR_OVERFLOW = 3'd4;
    localparam logic [2:0] c_ERR_NOTFOUND = 3'd5;
    localparam logic [2:0] c_ERR_BAD_OP   = 3'd6;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);
    localparam logic [c_IDX_W:0]   c_CNT_ONE  = (c_IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Slot storage
    logic                r_valid    [DEPTH];
    logic [3:0]          r_pid      [DEPTH];
    logic [6:0]          r_slot_qty [DEPTH];

    // Latched command
    logic [1:0]          r_op;
    logic [3:0]          r_id;
    logic [3:0]          r_qty;

    // Scan results
    logic [c_IDX_W-1:0]  r_scan_idx;
    logic                r_match_found;
    logic [c_IDX_W-1:0]  r_match_idx;
    logic                r_free_found;
    logic [c_IDX_W-1:0]  r_free_idx;

    logic [2:0]          r_error;
    logic [15:0]         r_total;
    logic [c_IDX_W:0]    r_item_cnt;

    logic [2:0]          w_val_err;
    logic [2:0]          w_commit_err;
    logic [7:0]          w_price;
    logic [11:0]         w_prod;
    logic [6:0]          w_match_qty;
    logic [7:0]          w_sum;
    logic [6:0]          w_diff;

    //--------------------------------------------------------------------------
    // Price ROM, indexed by the latched product ID
    //--------------------------------------------------------------------------
    always_comb begin
        w_price = 8'd0;
        case (r_id)
            4'd0:    w_price = 8'd5;
            4'd1:    w_price = 8'd8;
            4'd2:    w_price = 8'd12;
            4'd3:    w_price = 8'd3;
            4'd4:    w_price = 8'd20;
            4'd5:    w_price = 8'd7;
            4'd6:    w_price = 8'd15;
            4'd7:    w_price = 8'd9;
            4'd8:    w_price = 8'd4;
            4'd9:    w_price = 8'd11;
            4'd10:   w_price = 8'd6;
            4'd11:   w_price = 8'd25;
            default: w_price = 8'd0;
        endcase
    end

    assign w_prod      = {8'd0, r_qty} * {4'd0, w_price};
    assign w_match_qty = r_slot_qty[r_match_idx];
    assign w_sum       = {1'b0, w_match_qty} + {4'd0, r_qty};
    assign w_diff      = w_match_qty - {3'd0, r_qty};

    //--------------------------------------------------------------------------
    // Operand validation on the raw inputs, evaluated at acceptance
    //--------------------------------------------------------------------------
    always_comb begin
        w_val_err = c_ERR_OK;
        if (Op == c_OP_RSVD) begin
            w_val_err = c_ERR_BAD_OP;
        end else if (Op != c_OP_CLEAR) begin
            if (int'(ProductID) >= NUM_PRODUCTS) begin
                w_val_err = c_ERR_BAD_ID;
            end else if (ProductQuantity == 4'd0) begin
                w_val_err = c_ERR_ZERO_QTY;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outcome of the commit step, from the scan results
    //--------------------------------------------------------------------------
    always_comb begin
        w_commit_err = c_ERR_OK;
        case (r_op)
            c_OP_ADD: begin
                if (r_match_found) begin
                    if (int'(w_sum) > MAX_QTY) begin
                        w_commit_err = c_ERR_OVERFLOW;
                    end
                end else if (!r_free_found) begin
                    w_commit_err = c_ERR_FULL;
                end
            end
            c_OP_REMOVE: begin
                if (!r_match_found || ({3'd0, r_qty} > w_match_qty)) begin
                    w_commit_err = c_ERR_NOTFOUND;
                end
            end
            default: w_commit_err = c_ERR_OK;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next state and status outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        Busy         = 1'b1;
        Done_Pulse   = 1'b0;
        case (r_state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Enable_Pulse) begin
                    if (w_val_err != c_ERR_OK) begin
                        w_next_state = S_DONE;
                    end else if (Op == c_OP_CLEAR) begin
                        w_next_state = S_COMMIT;
                    end else begin
                        w_next_state = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (r_scan_idx == c_LAST_IDX) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                Done_Pulse   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath: command latch, scan bookkeeping, slot and total updates.
    // Error is written on the edge that enters DONE so it changes together
    // with Done_Pulse.
    //--------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]    <= 1'b0;
                r_pid[i]      <= 4'd0;
                r_slot_qty[i] <= 7'd0;
            end
            r_op          <= 2'd0;
            r_id          <= 4'd0;
            r_qty         <= 4'd0;
            r_scan_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_error       <= c_ERR_OK;
            r_total       <= 16'd0;
            r_item_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Enable_Pulse) begin
                        r_op          <= Op;
                        r_id          <= ProductID;
                        r_qty         <= ProductQuantity;
                        r_scan_idx    <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        if (w_val_err != c_ERR_OK) begin
                            r_error <= w_val_err;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_valid[r_scan_idx]) begin
                        if (!r_match_found && (r_pid[r_scan_idx] == r_id)) begin
                            r_match_found <= 1'b1;
                            r_match_idx   <= r_scan_idx;
                        end
                    end else if (!r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan_idx;
                    end
                    r_scan_idx <= r_scan_idx + c_IDX_W'(1);
                end
                S_COMMIT: begin
                    r_error <= w_commit_err;
                    if (r_op == c_OP_CLEAR) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            r_valid[i]    <= 1'b0;
                            r_pid[i]      <= 4'd0;
                            r_slot_qty[i] <= 7'd0;
                        end
                        r_total    <= 16'd0;
                        r_item_cnt <= '0;
                    end else if (w_commit_err == c_ERR_OK) begin
                        if (r_op == c_OP_ADD) begin
                            if (r_match_found) begin
                                r_slot_qty[r_match_idx] <= w_sum[6:0];
                            end else begin
                                r_valid[r_free_idx]    <= 1'b1;
                                r_pid[r_free_idx]      <= r_id;
                                r_slot_qty[r_free_idx] <= {3'd0, r_qty};
                                r_item_cnt             <= r_item_cnt + c_CNT_ONE;
                            end
                            r_total <= r_total + {4'd0, w_prod};
                        end else begin
                            // Remove: slots are never compacted, an emptied
                            // slot simply becomes a free hole.
                            r_slot_qty[r_match_idx] <= w_diff;
                            if (w_diff == 7'd0) begin
                                r_valid[r_match_idx] <= 1'b0;
                                r_item_cnt           <= r_item_cnt - c_CNT_ONE;
                            end
                            r_total <= r_total - {4'd0, w_prod};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Error        = r_error;
    assign TotalPrice   = r_total;
    assign ItemCount    = r_item_cnt;
    assign Rd_Valid     = r_valid[Rd_Index];
    assign Rd_ProductID = r_pid[Rd_Index];
    assign Rd_Quantity  = r_slot_qty[Rd_Index];

endmodule

`default_nettype wire

// File: doc/basket_controller.md
Name: basket_controller

Overview:
- Holds the customer basket for the sale terminal: up to DEPTH line items (product ID, quantity) plus a running total price.
- Sits directly downstream of the terminal state machine. It consumes that machine's enable pulse, product ID and product quantity, and applies add, remove or clear commands.
- Exposes the total, the item count and a random-access read port to the display path.
- Uses a slot-scan FSM so that a repeated product merges into its existing line.

Parameters:
DEPTH, 8, number of basket slots (power of two)
NUM_PRODUCTS, 12, valid product IDs are 0..NUM_PRODUCTS-1
MAX_QTY, 99, maximum quantity held in one slot

Ports:
CLOCK_50  in  1  system clock
RESET  in  1  synchronous, active-high reset
Enable_Pulse  in  1  one-cycle command strobe
Op  in  2  00 add, 01 remove, 10 clear, 11 reserved
ProductID  in  4  product ID operand
ProductQuantity  in  4  quantity operand, 0..15
Busy  out  1  high while a command is in progress
Done_Pulse  out  1  one-cycle pulse at command completion
Error  out  3  status of the last command: 0 ok, 1 bad ID, 2 zero qty, 3 full, 4 overflow, 5 not found/underflow, 6 bad op
TotalPrice  out  16  sum over valid slots of qty*price
ItemCount  out  4  number of valid slots
Rd_Index  in  3  display read slot index
Rd_Valid  out  1  slot valid
Rd_ProductID  out  4  slot product ID
Rd_Quantity  out  7  slot quantity

Behaviour:
- Reset: all slots invalid, slot contents 0. Busy=0, Done_Pulse=0, Error=0, TotalPrice=0, ItemCount=0, FSM in IDLE.
- Reset is synchronous and overrides everything, including a command mid-scan; the command is discarded.
- Price ROM (8-bit, internal), IDs 0..11: 5, 8, 12, 3, 20, 7, 15, 9, 4, 11, 6, 25.
- Read port: Rd_* are combinational from slot storage at Rd_Index. They are unaffected by Busy.
- Command capture: accepted only in IDLE on Enable_Pulse=1. Op, ProductID and ProductQuantity are latched on acceptance.
- Enable_Pulse while Busy is silently ignored. It causes no error and no queuing.
- Validation happens in IDLE on acceptance:
  - Op=11 -> error 6.
  - Add/remove with ID>=NUM_PRODUCTS -> error 1.
  - Add/remove with quantity 0 -> error 2.
  - Any error -> go to DONE directly; no state change.
- Clear (Op=10): goes to COMMIT directly. It invalidates all slots, sets TotalPrice=0 and ItemCount=0.
- FSM states: IDLE -> SCAN -> COMMIT -> DONE -> IDLE.
- SCAN: visits slot i=0..DEPTH-1, one per cycle.
  - Records the first valid slot whose ID matches (match index).
  - Records the lowest-index invalid slot (free index).
  - Leaves for COMMIT after slot DEPTH-1.
- COMMIT, add:
  - Match found and qty+operand<=MAX_QTY -> slot qty += operand.
  - Match found and qty+operand>MAX_QTY -> error 4, no change.
  - No match and a free slot exists -> the lowest free slot gets {valid, ID, operand}; ItemCount+1.
  - No match and no free slot -> error 3.
  - On success, TotalPrice += operand*price(ID), using a 4x8 multiply zero-extended to 16 bits.
- COMMIT, remove:
  - No match, or operand>slot qty -> error 5, no change.
  - Otherwise slot qty -= operand and TotalPrice -= operand*price(ID).
  - If the quantity reaches 0, the slot becomes invalid and ItemCount-1. There is no compaction, so later slots keep their indices.
- DONE: Done_Pulse=1 for exactly one cycle; Error is updated in the same cycle. Then the FSM returns to IDLE.
- Error holds its value until the next accepted command's Done_Pulse.
- Busy is 1 from the cycle after acceptance through the DONE cycle inclusive.
- Latency from Enable_Pulse to Done_Pulse:
  - add/remove: DEPTH+2 cycles (10 at default).
  - clear: 2 cycles.
  - validation error: 1 cycle.
- Width rule: TotalPrice worst case is 8*99*25 = 19800, so no overflow in 16 bits. No saturation is needed.

Test Plan:
- RESET held 2 cycles, then add ID3 qty2 -> Done_Pulse 10 cycles after the strobe, Error=0, TotalPrice=6, ItemCount=1, Rd_Index=0 reads {1,3,2}.
- Then add ID3 qty5 -> merge into slot 0: qty 7, TotalPrice=21, ItemCount=1. A second Enable_Pulse 3 cycles into this command is ignored, and the final state is identical.
- Add IDs 0..7 qty1 from empty -> ItemCount=8, TotalPrice=79. Then add ID8 qty1 -> Error=3, totals unchanged. Then remove ID2 qty1 -> slot 2 invalid, ItemCount=7, TotalPrice=67. Then add ID8 qty1 -> lands in slot 2.
- Add ID11 qty15 six times -> qty 90, TotalPrice=2250. A seventh add -> Error=4, qty stays 90. Remove ID11 qty91 -> Error=5. Remove ID11 qty90 -> ItemCount=0, TotalPrice=0.
- Add ID12 qty1 -> Error=1, Done_Pulse 1 cycle after the strobe. Add ID0 qty0 -> Error=2. Op=11 -> Error=6.
- Add ID5 qty4 with RESET asserted during SCAN -> Busy=0, no Done_Pulse, TotalPrice=0, all Rd_Valid=0. A clear with a non-empty basket -> Done_Pulse 2 cycles after the strobe, all counters 0.
